phy_rx_destripe: RTL and testbench
==================================

PHY_RX_DESTRIPE -- requirements
Module: phy_rx_destripe

Interface
REQ-001 Parameter COM, default 8'hBC: alignment symbol marking a 4-lane group boundary.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in words; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  8  serialized byte stream from the phy_tx mux stage.
REQ-006 valid_in  input  1  data_in carries a valid byte this cycle.
REQ-007 ready_in  input  1  downstream accepts the head word this cycle.
REQ-008 out0, out1, out2, out3  output  8 each  lane bytes of the head word.
REQ-009 valid0, valid1, valid2, valid3  output  1 each  per-lane valid flags of the head word.
REQ-010 word_valid  output  1  FIFO non-empty; head word presented.
REQ-011 fifo_count  output  3  number of stored words, 0..DEPTH.
REQ-012 locked  output  1  high in state LOCK.
REQ-013 align_err  output  1  one-cycle pulse on a mid-group COM.
REQ-014 overflow  output  1  sticky; set when a completed word is dropped.

Function
REQ-015 FSM states are HUNT and LOCK; locked = (state == LOCK).
REQ-016 In HUNT, all bytes are discarded; valid_in=1 with data_in=COM SHALL move the FSM to LOCK with lane counter cnt=0.
REQ-017 In LOCK, each cycle with no COM SHALL capture data_in into lane[cnt] and valid_in into lane_valid[cnt], then increment cnt modulo 4.
REQ-018 Lane order: first byte after COM goes to lane 0, then lanes 1, 2, 3.
REQ-019 At cnt=3, the assembled group {bytes, valid flags} SHALL be pushed into the FIFO on the same edge, provided at least one lane valid flag is 1.
REQ-020 When a completed group has all four valid flags at 0, the group is not pushed and the FSM SHALL return to HUNT (link idle).
REQ-021 valid_in=1 with data_in=COM in LOCK at cnt=0: realign only; no capture, cnt stays 0, no error.
REQ-022 valid_in=1 with data_in=COM in LOCK at cnt=1..3: discard the partial group, set cnt=0, stay in LOCK, pulse align_err for one cycle.
REQ-023 A data byte equal to COM with valid_in=0 is treated as ordinary invalid data.
REQ-024 The FIFO is synchronous with DEPTH entries of 36 bits each; head entry drives out0..3 and valid0..3 combinationally from storage.
REQ-025 When empty: word_valid=0 and out0..3 / valid0..3 are driven to 0.
REQ-026 A pop occurs when word_valid & ready_in; ready_in while empty is ignored.
REQ-027 Push when full without a same-cycle pop: the word is dropped, FIFO state is unchanged, overflow is set.
REQ-028 Push and pop in the same cycle, including when full: both take effect and fifo_count is unchanged.
REQ-029 Latency: the last byte of a group captured on edge N SHALL appear at the head by edge N (word_valid high in cycle N+1) if the FIFO was empty.
REQ-030 Read and write pointers wrap modulo DEPTH; fifo_count saturates at DEPTH and never underflows.

Reset
REQ-031 Reset asserted SHALL immediately set: state=HUNT, cnt=0, all lane registers 0, FIFO empty, overflow=0, align_err=0, locked=0, word_valid=0, outputs 0.
REQ-032 Reset asserted mid-group or with a non-empty FIFO discards all partial and stored data.
REQ-033 After reset deassertion, the block SHALL resume operation in HUNT on the next rising edge.

Verification
REQ-034 Scenario: COM, then FF,EE,DD,CC all valid, ready_in=1 -> one word out0..3=FF,EE,DD,CC, valid0..3=1111, word_valid one cycle later; locked=1.
REQ-035 Scenario: COM, then BB(v),AA(v),99(v=0),88(v) -> valid0..3=1,1,0,1 and out2=99 is passed through.
REQ-036 Scenario: COM, then 4 invalid bytes -> no push; locked returns to 0.
REQ-037 Scenario: COM, FF, EE, COM, then 11,22,33,44 -> align_err pulses once; the only pushed word is 11,22,33,44.
REQ-038 Scenario: ready_in=0, push 5 groups -> fifo_count=4, overflow=1, 5th word lost; then ready_in=1 -> pops 4 words in order.
REQ-039 Scenario: reset asserted while fifo_count=2 and cnt=2 -> all outputs 0 asynchronously; after release, bytes before the next COM are ignored.

Source files
------------

// File: rtl/phy_rx_destripe.sv
// rtl/phy_rx_destripe.sv - regroups a COM-aligned byte stream into 4-lane words
// and buffers the assembled words in a small synchronous FIFO.
module phy_rx_destripe #(
  parameter logic [7:0] COM   = 8'hBC,
  parameter int         DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       ready_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       valid0,
  output logic       valid1,
  output logic       valid2,
  output logic       valid3,
  output logic       word_valid,
  output logic [2:0] fifo_count,
  output logic       locked,
  output logic       align_err,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {HUNT, LOCK} state_t;

  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [7:0]    r_lane [0:3];
  logic [3:0]    r_lane_v;
  logic          r_align_err;
  logic          r_overflow;
  logic [35:0]   r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;

  logic          w_com;
  logic          w_capture;
  logic          w_group_any;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_write;
  logic [35:0]   w_word;
  logic [35:0]   w_head;

  assign w_com       = valid_in && (data_in == COM);
  assign w_capture   = (r_state == LOCK) && !w_com;
  assign w_group_any = valid_in | (|r_lane_v[2:0]);
  assign w_push      = w_capture && (r_cnt == 2'd3) && w_group_any;
  // The last lane is taken straight from the input so the word lands on the capturing edge.
  assign w_word      = {valid_in, r_lane_v[2:0], data_in, r_lane[2], r_lane[1], r_lane[0]};

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && ready_in;
  assign w_write = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= HUNT;
      r_cnt       <= 2'd0;
      r_lane_v    <= 4'd0;
      r_align_err <= 1'b0;
      for (int i = 0; i < 4; i++) r_lane[i] <= 8'd0;
    end else begin
      r_align_err <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_com) begin
            r_state <= LOCK;
            r_cnt   <= 2'd0;
          end
        end
        LOCK: begin
          if (w_com) begin
            r_align_err <= (r_cnt != 2'd0);
            r_cnt       <= 2'd0;
          end else begin
            r_lane[r_cnt]   <= data_in;
            r_lane_v[r_cnt] <= valid_in;
            r_cnt           <= r_cnt + 2'd1;
            // An all-invalid group means the link went idle; hunt for the next COM.
            if (r_cnt == 2'd3 && !w_group_any) r_state <= HUNT;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 36'd0;
    end else begin
      if (w_write) begin
        r_mem[r_wp] <= w_word;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_write && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_write && w_pop) r_count <= r_count - CW'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_head     = w_empty ? 36'd0 : r_mem[r_rp];
  assign out0       = w_head[7:0];
  assign out1       = w_head[15:8];
  assign out2       = w_head[23:16];
  assign out3       = w_head[31:24];
  assign valid0     = w_head[32];
  assign valid1     = w_head[33];
  assign valid2     = w_head[34];
  assign valid3     = w_head[35];
  assign word_valid = !w_empty;
  assign fifo_count = 3'(r_count);
  assign locked     = (r_state == LOCK);
  assign align_err  = r_align_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_phy_rx_destripe.sv
// tb/tb_phy_rx_destripe.sv - scoreboard bench for phy_rx_destripe
// with a queue-based reference model of grouping and buffering.
module tb_phy_rx_destripe;

  localparam logic [7:0] COM   = 8'hBC;
  localparam int         DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] out0, out1, out2, out3;
  logic       valid0, valid1, valid2, valid3;
  logic       word_valid;
  logic [2:0] fifo_count;
  logic       locked;
  logic       align_err;
  logic       overflow;

  phy_rx_destripe #(.COM(COM), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .word_valid(word_valid), .fifo_count(fifo_count), .locked(locked),
    .align_err(align_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]  m_grp [$];
  logic [35:0] m_fifo [$];
  logic [35:0] sb [$];
  bit          m_locked = 0;
  bit          m_ovf    = 0;
  bit          m_aerr   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [35:0] head_bus();
    return {valid3, valid2, valid1, valid0, out3, out2, out1, out0};
  endfunction

  // One cycle of the reference behaviour: pop first, then group/lock rules, then push.
  task automatic model_step(input logic [7:0] d, input logic v, input logic r);
    bit com, pop, full, anyv, newaerr;
    logic [35:0] word;
    com     = v && (d == COM);
    full    = (m_fifo.size() == DEPTH);
    pop     = (m_fifo.size() > 0) && r;
    newaerr = 0;
    if (pop) sb.push_back(m_fifo.pop_front());
    if (!m_locked) begin
      if (com) begin m_locked = 1; m_grp.delete(); end
    end else if (com) begin
      newaerr = (m_grp.size() != 0);
      m_grp.delete();
    end else begin
      m_grp.push_back({v, d});
      if (m_grp.size() == 4) begin
        anyv = 0;
        word = '0;
        for (int i = 0; i < 4; i++) begin
          anyv |= m_grp[i][8];
          word[8*i +: 8] = m_grp[i][7:0];
          word[32+i]     = m_grp[i][8];
        end
        if (!anyv) m_locked = 0;
        else if (!full || pop) m_fifo.push_back(word);
        else m_ovf = 1;
        m_grp.delete();
      end
    end
    m_aerr = newaerr;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic [7:0] d, input logic v, input logic r);
    int e_cnt;
    bit e_lock, e_ovf, e_aerr;
    data_in = d; valid_in = v; ready_in = r;
    e_cnt = m_fifo.size(); e_lock = m_locked; e_ovf = m_ovf; e_aerr = m_aerr;
    model_step(d, v, r);
    @(negedge clk);
    chk("fifo_count", 64'(fifo_count), 64'(e_cnt));
    chk("locked", 64'(locked), 64'(e_lock));
    chk("word_valid", 64'(word_valid), 64'(e_cnt != 0));
    chk("overflow", 64'(overflow), 64'(e_ovf));
    chk("align_err", 64'(align_err), 64'(e_aerr));
    if (e_cnt == 0) chk("empty_head", 64'(head_bus()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_count"}, 64'(fifo_count), 64'd0);
    chk({nm, "_wv"}, 64'(word_valid), 64'd0);
    chk({nm, "_locked"}, 64'(locked), 64'd0);
    chk({nm, "_flags"}, 64'({overflow, align_err}), 64'd0);
    chk({nm, "_head"}, 64'(head_bus()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && word_valid === 1'b1 && ready_in === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_pop", 64'(head_bus()), 64'hDEAD);
      else chk("popped_word", 64'(head_bus()), 64'(sb.pop_front()));
    end
  end

  initial begin
    reset = 1'b1; data_in = 8'h00; valid_in = 1'b0; ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    cyc(COM, 1, 1); cyc(8'hFF, 1, 1); cyc(8'hEE, 1, 1); cyc(8'hDD, 1, 1); cyc(8'hCC, 1, 1);
    idle(6);

    cyc(COM, 1, 1); cyc(8'hBB, 1, 1); cyc(8'hAA, 1, 1); cyc(8'h99, 0, 1); cyc(8'h88, 1, 1);
    idle(6);

    cyc(COM, 1, 1);
    for (int i = 0; i < 4; i++) cyc(8'($urandom), 0, 1);
    idle(2);

    cyc(COM, 1, 1); cyc(8'hFF, 1, 1); cyc(8'hEE, 1, 1); cyc(COM, 1, 1);
    cyc(8'h11, 1, 1); cyc(8'h22, 1, 1); cyc(8'h33, 1, 1); cyc(8'h44, 1, 1);
    idle(6);

    cyc(COM, 1, 0);
    for (int i = 0; i < 20; i++) cyc(8'(i + 1), 1, 0);
    idle(10);

    cyc(COM, 1, 0);
    for (int i = 0; i < 10; i++) cyc(8'(8'h40 + i), 1, 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_rst");
    m_grp.delete(); m_fifo.delete(); sb.delete();
    m_locked = 0; m_ovf = 0; m_aerr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(8'(8'h10 + i), 1, 1);
    cyc(COM, 1, 1); cyc(8'h01, 1, 1); cyc(8'h02, 1, 1); cyc(8'h03, 1, 1); cyc(8'h04, 1, 1);
    idle(6);

    for (int i = 0; i < 800; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 5) == 0) ? COM : 8'($urandom);
      cyc(d, $urandom_range(0, 7) != 0, (i < 400) ? ($urandom_range(0, 3) == 0)
                                                   : ($urandom_range(0, 2) != 0));
    end

    idle(20);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("model_fifo_drained", 64'(m_fifo.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
